// File: rtl/hedios_pkg.sv
// Shared Hedios packet opcodes, reply codes and the command-engine state encoding.
// Used by the command engine and by the RX/TX serial blocks.
package hedios_pkg;

    localparam logic [7:0] OP_PING    = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_ACTION  = 8'h03;
    localparam logic [7:0] OP_RESET   = 8'h04;
    localparam logic [7:0] OP_STREAM  = 8'h05;

    localparam logic [7:0] RP_PING    = 8'h81;
    localparam logic [7:0] RP_READ    = 8'h82;
    localparam logic [7:0] RP_ACTION  = 8'h83;
    localparam logic [7:0] RP_RESET   = 8'h84;
    localparam logic [7:0] RP_STREAM  = 8'h85;

    localparam logic [7:0] NACK       = 8'hEE;
    localparam logic [7:0] STREAM_CMD = 8'h90;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_REPLY,
        S_STREAM,
        S_PING
    } fsm_state_t;

endpackage

// File: rtl/hedios_stream_timer.sv
// Periodic stream timer: period register, free-running counter, burst-pending and sticky overrun flags.
module hedios_stream_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        period_we,
    input  logic [31:0] period_in,
    input  logic        clear,
    output logic        pending,
    output logic        overrun
);

    logic [31:0] period;
    logic [31:0] count;
    logic        expire;

    assign expire = (period != 32'd0) && (count == period - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            period  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (period_we) begin
            period <= period_in;
            count  <= 32'd0;
            if (period_in == 32'd0)
                pending <= 1'b0;
        end else begin
            if (period != 32'd0)
                count <= expire ? 32'd0 : count + 32'd1;
            // An expiry with a burst still outstanding is lost and flagged.
            if (expire && !pending)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
            if (expire && pending)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/hedios_command_engine.sv
// Hedios command engine: decodes host packets from the RX queue, fires user side effects,
// and arbitrates replies, outbound pings and periodic slot bursts onto the TX queue.
module hedios_command_engine #(
    parameter int SLOT_COUNT   = 8,
    parameter int SLOT_WIDTH   = 32,
    parameter int ACTION_COUNT = 4,
    parameter int PARAM_WIDTH  = 24,
    parameter int RST_CYCLES   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_empty,
    input  logic [7:0]                       rx_command,
    input  logic [31:0]                      rx_data,
    output logic                             rx_pop_packet,
    input  logic                             tx_full,
    output logic [7:0]                       tx_command,
    output logic [31:0]                      tx_data,
    output logic                             tx_push_packet,
    input  logic [SLOT_COUNT*SLOT_WIDTH-1:0] slots,
    input  logic                             send_ping,
    output logic [ACTION_COUNT-1:0]          action_strobe,
    output logic [PARAM_WIDTH-1:0]           action_param,
    output logic                             rst_device,
    output logic                             stream_overrun
);
    import hedios_pkg::*;

    localparam int SIW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam int RCW = $clog2(RST_CYCLES + 1);

    fsm_state_t       state, state_nx;
    logic [7:0]       cmd_q, reply_cmd, ex_cmd;
    logic [31:0]      data_q, reply_data, ex_data;
    logic [SIW-1:0]   burst_idx;
    logic [RCW-1:0]   rst_cnt;
    logic             ping_q, ping_pending, stream_pending, burst_last;
    logic             ex_action, ex_reset, ex_period, read_ok, act_ok, exec_en;
    logic [SLOT_WIDTH-1:0] slot_arr [SLOT_COUNT];

    for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_slot
        assign slot_arr[g] = slots[g*SLOT_WIDTH +: SLOT_WIDTH];
    end

    assign exec_en = (state == S_EXEC);
    assign read_ok = data_q < 32'(SLOT_COUNT);
    assign act_ok  = {1'b0, data_q[31:24]} < 9'(ACTION_COUNT);

    // Command decode, evaluated on the latched packet; only acted on in EXEC.
    always_comb begin
        ex_cmd    = NACK;
        ex_data   = {24'h0, cmd_q};
        ex_action = 1'b0;
        ex_reset  = 1'b0;
        ex_period = 1'b0;
        case (cmd_q)
            OP_PING: begin
                ex_cmd  = RP_PING;
                ex_data = data_q;
            end
            OP_READ: if (read_ok) begin
                ex_cmd  = RP_READ;
                ex_data = 32'(slot_arr[data_q[SIW-1:0]]);
            end
            OP_ACTION: if (act_ok) begin
                ex_cmd    = RP_ACTION;
                ex_data   = data_q;
                ex_action = 1'b1;
            end
            OP_RESET: begin
                ex_cmd   = RP_RESET;
                ex_data  = 32'd0;
                ex_reset = 1'b1;
            end
            OP_STREAM: begin
                ex_cmd    = RP_STREAM;
                ex_data   = data_q;
                ex_period = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx       = state;
        rx_pop_packet  = 1'b0;
        tx_command     = 8'h00;
        tx_data        = 32'd0;
        tx_push_packet = 1'b0;
        burst_last     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_empty) begin
                    rx_pop_packet = 1'b1;
                    state_nx      = S_EXEC;
                end else if (ping_pending) begin
                    state_nx = S_PING;
                end else if (stream_pending) begin
                    state_nx = S_STREAM;
                end
            end
            S_EXEC: state_nx = S_REPLY;
            S_REPLY: begin
                tx_command = reply_cmd;
                tx_data    = reply_data;
                if (!tx_full) begin
                    tx_push_packet = 1'b1;
                    state_nx       = S_IDLE;
                end
            end
            S_PING: begin
                tx_command = OP_PING;
                if (!tx_full) begin
                    tx_push_packet = 1'b1;
                    state_nx       = S_IDLE;
                end
            end
            S_STREAM: begin
                tx_command = STREAM_CMD;
                tx_data    = 32'(slot_arr[burst_idx]);
                if (!tx_full) begin
                    tx_push_packet = 1'b1;
                    if (burst_idx == SIW'(SLOT_COUNT - 1)) begin
                        burst_last = 1'b1;
                        state_nx   = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Never consume or emit a packet in a cycle that is being reset.
        if (rst) begin
            rx_pop_packet  = 1'b0;
            tx_push_packet = 1'b0;
            burst_last     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_q        <= 8'h00;
            data_q       <= 32'd0;
            reply_cmd    <= 8'h00;
            reply_data   <= 32'd0;
            burst_idx    <= '0;
            ping_q       <= 1'b0;
            ping_pending <= 1'b0;
            rst_cnt      <= '0;
            action_param <= '0;
        end else begin
            state  <= state_nx;
            ping_q <= send_ping;
            if (rx_pop_packet) begin
                cmd_q  <= rx_command;
                data_q <= rx_data;
            end
            if (exec_en) begin
                reply_cmd  <= ex_cmd;
                reply_data <= ex_data;
            end
            if (exec_en && ex_action)
                action_param <= data_q[PARAM_WIDTH-1:0];
            if (state != S_STREAM)
                burst_idx <= '0;
            else if (tx_push_packet)
                burst_idx <= burst_idx + SIW'(1);
            if (state == S_PING && tx_push_packet)
                ping_pending <= 1'b0;
            else if (send_ping && !ping_q)
                ping_pending <= 1'b1;
            if (exec_en && ex_reset)
                rst_cnt <= RCW'(RST_CYCLES);
            else if (rst_cnt != '0)
                rst_cnt <= rst_cnt - RCW'(1);
        end
    end

    assign rst_device    = (rst_cnt != '0);
    assign action_strobe = (exec_en && ex_action) ? (ACTION_COUNT'(1) << data_q[31:24]) : '0;

    hedios_stream_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .period_we (exec_en && ex_period),
        .period_in (data_q),
        .clear     (burst_last),
        .pending   (stream_pending),
        .overrun   (stream_overrun)
    );

endmodule
